neq5_stream_monitor: RTL and testbench

- Registered, handshaked stage that consumes 5-bit operand pairs, evaluates inequality (a != b, bitwise XOR then OR-reduce), and presents the registered result downstream.
- Keeps a saturating mismatch count, a consecutive-mismatch run length, and a sticky alarm when the run reaches a programmed limit.
- Sits directly downstream of the operand source and feeds result consumers and status readback.

---
 rtl/neq5_stream_monitor_pkg.sv | 6 +
 rtl/neq5_stream_monitor_neq_core.sv | 16 +
 rtl/neq5_stream_monitor.sv | 94 +++++++++
 tb/tb_neq5_stream_monitor.sv | 135 +++++++++++++
 4 files changed

// File: rtl/neq5_stream_monitor_pkg.sv
// Shared types and defaults for the inequality stream monitor.
package neq5_stream_monitor_pkg;
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;
  localparam int DEF_WIDTH = 5;
  localparam int DEF_CNT_W = 8;
endpackage

// File: rtl/neq5_stream_monitor_neq_core.sv
// Combinational WIDTH-bit inequality: per-bit XOR, then OR-reduce.
module neq_core #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             neq
);
  logic [WIDTH-1:0] w_diff;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign w_diff[i] = a[i] ^ b[i];
  end

  assign neq = |w_diff;
endmodule

// File: rtl/neq5_stream_monitor.sv
// One-entry handshaked inequality stage with saturating mismatch/run counters
// and a sticky alarm raised when the mismatch run reaches RUN_LIMIT.
module neq5_stream_monitor
  import neq5_stream_monitor_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int RUN_LIMIT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_neq,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  input  logic             clr,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [CNT_W-1:0] run_len,
  output logic             alarm
);
  state_t           r_state, w_state_nxt;
  logic             r_neq;
  logic [WIDTH-1:0] r_a, r_b;
  logic [CNT_W-1:0] r_cnt, r_run;
  logic             r_alarm;

  logic             w_neq, w_acc, w_fire;
  logic [CNT_W-1:0] w_cnt_nxt, w_run_nxt;

  neq_core #(.WIDTH(WIDTH)) u_neq (.a(a), .b(b), .neq(w_neq));

  assign out_valid = (r_state == FULL);
  assign in_ready  = !out_valid || out_ready;
  assign w_acc     = in_valid && in_ready;
  assign w_fire    = out_valid && out_ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY:   if (w_acc) w_state_nxt = FULL;
      FULL:    if (w_fire && !w_acc) w_state_nxt = EMPTY;
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= EMPTY;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_neq <= 1'b0;
    end else if (w_acc) begin
      r_a   <= a;
      r_b   <= b;
      r_neq <= w_neq;
    end
  end

  // Both counters stick at all-ones instead of wrapping.
  assign w_cnt_nxt = (w_neq && !(&r_cnt)) ? r_cnt + CNT_W'(1) : r_cnt;
  assign w_run_nxt = !w_neq ? '0 : ((&r_run) ? r_run : r_run + CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_run   <= '0;
      r_alarm <= 1'b0;
    end else if (clr) begin
      r_cnt   <= '0;
      r_run   <= '0;
      r_alarm <= 1'b0;
    end else if (w_acc) begin
      r_cnt <= w_cnt_nxt;
      r_run <= w_run_nxt;
      if (w_run_nxt == CNT_W'(RUN_LIMIT)) r_alarm <= 1'b1;
    end
  end

  assign out_neq      = r_neq;
  assign out_a        = r_a;
  assign out_b        = r_b;
  assign mismatch_cnt = r_cnt;
  assign run_len      = r_run;
  assign alarm        = r_alarm;
endmodule

// File: tb/tb_neq5_stream_monitor.sv
// Directed bench: an 8-bit-counter instance and a 3-bit-counter instance share stimulus.
module tb_neq5_stream_monitor;
  logic       clk = 1'b0;
  logic       rst_n, in_valid, out_ready, clr;
  logic [4:0] a, b;

  logic       rdy8, vld8, neq8, alm8;
  logic [4:0] oa8, ob8;
  logic [7:0] cnt8, run8;
  logic       rdy3, vld3, neq3, alm3;
  logic [4:0] oa3, ob3;
  logic [2:0] cnt3, run3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  neq5_stream_monitor #(.WIDTH(5), .CNT_W(8), .RUN_LIMIT(3)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy8), .a(a), .b(b),
    .out_valid(vld8), .out_ready(out_ready), .out_neq(neq8), .out_a(oa8), .out_b(ob8),
    .clr(clr), .mismatch_cnt(cnt8), .run_len(run8), .alarm(alm8));

  neq5_stream_monitor #(.WIDTH(5), .CNT_W(3), .RUN_LIMIT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy3), .a(a), .b(b),
    .out_valid(vld3), .out_ready(out_ready), .out_neq(neq3), .out_a(oa3), .out_b(ob3),
    .clr(clr), .mismatch_cnt(cnt3), .run_len(run3), .alarm(alm3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] ia, input logic [4:0] ib,
                       input logic ordy, input logic c);
    in_valid = v; a = ia; b = ib; out_ready = ordy; clr = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic st8(input string tag, input logic v, input logic n,
                     input logic [4:0] ea, input logic [7:0] c, input logic [7:0] r,
                     input logic al);
    chk({tag, "_vld"}, 32'(vld8), 32'(v));
    chk({tag, "_neq"}, 32'(neq8), 32'(n));
    chk({tag, "_a"},   32'(oa8),  32'(ea));
    chk({tag, "_cnt"}, 32'(cnt8), 32'(c));
    chk({tag, "_run"}, 32'(run8), 32'(r));
    chk({tag, "_alm"}, 32'(alm8), 32'(al));
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 5'h00, 5'h00, 1'b1, 1'b0);
    #12;
    st8("rst", 1'b0, 1'b0, 5'h00, 8'd0, 8'd0, 1'b0);
    chk("rst_rdy", 32'(rdy8), 32'd1);
    chk("rst_b",   32'(ob8),  32'd0);
    chk("rst_cnt3", 32'(cnt3), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    drive(1'b1, 5'h0A, 5'h0A, 1'b1, 1'b0); tick();
    st8("eq0", 1'b1, 1'b0, 5'h0A, 8'd0, 8'd0, 1'b0);

    drive(1'b1, 5'h0A, 5'h0B, 1'b1, 1'b0); tick();
    st8("b2b1", 1'b1, 1'b1, 5'h0A, 8'd1, 8'd1, 1'b0);
    chk("b2b1_b", 32'(ob8), 32'h0B);
    drive(1'b1, 5'h1F, 5'h0F, 1'b1, 1'b0); tick();
    st8("b2b2", 1'b1, 1'b1, 5'h1F, 8'd2, 8'd2, 1'b0);
    drive(1'b1, 5'h03, 5'h03, 1'b1, 1'b0); tick();
    st8("b2b3", 1'b1, 1'b0, 5'h03, 8'd2, 8'd0, 1'b0);

    // Backpressure: held result must not move and nothing is accepted.
    drive(1'b1, 5'h11, 5'h12, 1'b0, 1'b0); #1;
    chk("bp_rdy", 32'(rdy8), 32'd0);
    tick();
    st8("bp_hold", 1'b1, 1'b0, 5'h03, 8'd2, 8'd0, 1'b0);
    chk("bp_hold_b", 32'(ob8), 32'h03);
    out_ready = 1'b1; #1;
    chk("bp_rdy_pass", 32'(rdy8), 32'd1);
    tick();
    st8("bp_rel", 1'b1, 1'b1, 5'h11, 8'd3, 8'd1, 1'b0);

    drive(1'b1, 5'h01, 5'h02, 1'b1, 1'b0); tick();
    st8("run2", 1'b1, 1'b1, 5'h01, 8'd4, 8'd2, 1'b0);
    drive(1'b1, 5'h04, 5'h05, 1'b1, 1'b0); tick();
    st8("run3", 1'b1, 1'b1, 5'h04, 8'd5, 8'd3, 1'b1);
    drive(1'b1, 5'h07, 5'h07, 1'b1, 1'b0); tick();
    st8("run_eq", 1'b1, 1'b0, 5'h07, 8'd5, 8'd0, 1'b1);
    drive(1'b0, 5'h00, 5'h00, 1'b1, 1'b1); tick();
    st8("clr", 1'b0, 1'b0, 5'h07, 8'd0, 8'd0, 1'b0);

    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 5'(i), 5'(i + 1), 1'b1, 1'b0); tick();
    end
    chk("sat_cnt3", 32'(cnt3), 32'd7);
    chk("sat_run3", 32'(run3), 32'd7);
    chk("sat_alm3", 32'(alm3), 32'd1);
    chk("sat_cnt8", 32'(cnt8), 32'd9);
    chk("sat_run8", 32'(run8), 32'd9);

    drive(1'b1, 5'h1A, 5'h05, 1'b1, 1'b1); tick();
    st8("clr_acc", 1'b1, 1'b1, 5'h1A, 8'd0, 8'd0, 1'b0);
    chk("clr_acc_cnt3", 32'(cnt3), 32'd0);
    chk("clr_acc_alm3", 32'(alm3), 32'd0);
    chk("clr_acc_a3", 32'(oa3), 32'h1A);

    drive(1'b1, 5'h1B, 5'h05, 1'b1, 1'b0); tick();
    st8("pre_rst", 1'b1, 1'b1, 5'h1B, 8'd1, 8'd1, 1'b0);
    drive(1'b0, 5'h00, 5'h00, 1'b0, 1'b0);
    @(posedge clk); #3;
    chk("pre_rst_full", 32'(vld8), 32'd1);
    rst_n = 1'b0; #1;
    st8("arst", 1'b0, 1'b0, 5'h00, 8'd0, 8'd0, 1'b0);
    chk("arst_rdy", 32'(rdy8), 32'd1);
    chk("arst_vld3", 32'(vld3), 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    drive(1'b1, 5'h09, 5'h09, 1'b1, 1'b0); tick();
    st8("resume_eq", 1'b1, 1'b0, 5'h09, 8'd0, 8'd0, 1'b0);
    drive(1'b1, 5'h09, 5'h08, 1'b1, 1'b0); tick();
    st8("resume_ne", 1'b1, 1'b1, 5'h09, 8'd1, 8'd1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
